spectrum_bar_sequencer: RTL and testbench

Frame-level command generator directly upstream of the thick-line drawing stage. On each Start pulse it walks a bank of spectrum bin heights and issues one vertical bar per bin to the line drawer. For each bar it presents X0/Y0/X1/Y1/Thickness, pulses Go and waits for the drawer's Done. It replaces software-driven per-line register writes for the visualizer's bar display.

---
 rtl/spectrum_bar_sequencer.sv | 140 ++++++++++++++
 tb/tb_spectrum_bar_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_bar_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spectrum_bar_sequencer
// Purpose  : Walks a bank of spectrum bin heights and issues one vertical bar
//            per bin to a thick-line drawer (X0/Y0/X1/Y1/Thickness + Go,
//            handshaked on the drawer's Done).
// Ports    : clk, reset          - clock, synchronous active-high reset
//            Start, Bar_Thickness - frame request and per-frame thickness
//            Bin_Addr, Bin_Height - bin-height RAM read port (1-cycle latency)
//            Go, X0, X1, Y0, Y1, Thickness, Done - line drawer command port
//            Busy, Frame_Done     - frame status
// Revision : 1.0 - initial release
// ============================================================================
module spectrum_bar_sequencer #(
    parameter int NUM_BINS   = 32,
    parameter int BAR_PITCH  = 10,
    parameter int X_ORIGIN   = 4,
    parameter int Y_BASE     = 239,
    parameter int MAX_HEIGHT = 200,
    parameter int X_LIMIT    = 319
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Start,
    input  logic [8:0] Bar_Thickness,
    output logic [7:0] Bin_Addr,
    input  logic [7:0] Bin_Height,
    output logic       Go,
    output logic [8:0] X0,
    output logic [8:0] X1,
    output logic [7:0] Y0,
    output logic [7:0] Y1,
    output logic [8:0] Thickness,
    input  logic       Done,
    output logic       Busy,
    output logic       Frame_Done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_GUARD  = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;
    localparam logic [2:0] S_FINISH = 3'd7;

    // Bar height never exceeds either the clamp or the baseline row, so the
    // top-row subtraction below cannot underflow.
    localparam int         c_CLAMP_INT = (MAX_HEIGHT < Y_BASE) ? MAX_HEIGHT : Y_BASE;
    localparam logic [7:0] c_CLAMP     = 8'(c_CLAMP_INT);
    localparam logic [7:0] c_Y_BASE    = 8'(Y_BASE);
    localparam logic [9:0] c_X_ORIGIN  = 10'(X_ORIGIN);
    localparam logic [9:0] c_BAR_PITCH = 10'(BAR_PITCH);
    localparam logic [9:0] c_X_LIMIT   = 10'(X_LIMIT);
    localparam logic [7:0] c_LAST_IDX  = 8'(NUM_BINS - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [7:0] r_idx;
    logic [9:0] r_x_acc;
    logic       r_guard;
    logic [8:0] r_x;
    logic [7:0] r_y0;
    logic [7:0] r_y1;
    logic [8:0] r_thick;
    logic [7:0] w_height;
    logic [9:0] w_x_next;

    assign w_height = (Bin_Height < c_CLAMP) ? Bin_Height : c_CLAMP;
    assign w_x_next = r_x_acc + c_BAR_PITCH;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (Start) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_LATCH;
            // Empty bars skip the drawer entirely.
            S_LATCH:  w_next_state = (w_height == 8'd0) ? S_NEXT : S_ISSUE;
            S_ISSUE:  if (Done) w_next_state = S_GUARD;
            // Drawer's Done may still be high right after Go; skip two cycles
            // before trusting it as completion.
            S_GUARD:  if (r_guard) w_next_state = S_WAIT;
            S_WAIT:   if (Done) w_next_state = S_NEXT;
            S_NEXT:   w_next_state = ((r_idx == c_LAST_IDX) || (w_x_next > c_X_LIMIT))
                                     ? S_FINISH : S_FETCH;
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= 8'd0;
            r_x_acc <= 10'd0;
            r_guard <= 1'b0;
            r_x     <= 9'd0;
            r_y0    <= 8'd0;
            r_y1    <= 8'd0;
            r_thick <= 9'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_thick <= Bar_Thickness;
                        r_idx   <= 8'd0;
                        r_x_acc <= c_X_ORIGIN;
                    end
                end
                S_LATCH: begin
                    r_x  <= r_x_acc[8:0];
                    r_y0 <= c_Y_BASE;
                    r_y1 <= c_Y_BASE - w_height;
                end
                S_ISSUE: r_guard <= 1'b0;
                S_GUARD: r_guard <= 1'b1;
                S_NEXT: begin
                    r_idx   <= r_idx + 8'd1;
                    r_x_acc <= w_x_next;
                end
                default: ;
            endcase
        end
    end

    // The RAM sees the bin index directly; data returns while in LATCH.
    assign Bin_Addr   = r_idx;
    assign Go         = (r_state == S_ISSUE) && Done;
    assign X0         = r_x;
    assign X1         = r_x;
    assign Y0         = r_y0;
    assign Y1         = r_y1;
    assign Thickness  = r_thick;
    assign Busy       = (r_state != S_IDLE);
    assign Frame_Done = (r_state == S_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_spectrum_bar_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spectrum_bar_sequencer
// Purpose  : Self-checking bench. Two sequencer instances (4 and 40 bins)
//            share clock, reset, Start and thickness; each has its own bin
//            RAM and drawer model. Expected bar lists come from a
//            list-building model of the bar rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spectrum_bar_sequencer;

    localparam int c_NB0 = 4;
    localparam int c_NB1 = 40;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] thick = 9'd0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int hold_until = 0;
    int low_cycles = 20;
    bit never_fall = 1'b0;

    logic [7:0]  ram [2][256];
    int unsigned exp_q [2][$];
    logic [8:0]  exp_thick = 9'd0;
    int          fd_cnt [2];
    int          go_cnt [2];
    int          first_go_cyc [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic       go_o   [2];
    logic       busy_o [2];
    logic       fd_o   [2];
    logic       done_i [2];
    logic [7:0] addr_o [2];
    logic [7:0] bh_i   [2];
    logic [7:0] y0_o   [2];
    logic [7:0] y1_o   [2];
    logic [8:0] x0_o   [2];
    logic [8:0] x1_o   [2];
    logic [8:0] th_o   [2];

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int NB = (k == 0) ? c_NB0 : c_NB1;

        logic        dly = 1'b0;
        int          cnt = 0;
        int unsigned e;

        spectrum_bar_sequencer #(
            .NUM_BINS   (NB),
            .BAR_PITCH  (10),
            .X_ORIGIN   (4),
            .Y_BASE     (239),
            .MAX_HEIGHT (200),
            .X_LIMIT    (319)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .Start         (start),
            .Bar_Thickness (thick),
            .Bin_Addr      (addr_o[k]),
            .Bin_Height    (bh_i[k]),
            .Go            (go_o[k]),
            .X0            (x0_o[k]),
            .X1            (x1_o[k]),
            .Y0            (y0_o[k]),
            .Y1            (y1_o[k]),
            .Thickness     (th_o[k]),
            .Done          (done_i[k]),
            .Busy          (busy_o[k]),
            .Frame_Done    (fd_o[k])
        );

        // Synchronous-read bin RAM
        always @(posedge clk) bh_i[k] <= ram[k][addr_o[k]];

        // Drawer: Done stays high one cycle after Go, then low for low_cycles
        always @(posedge clk) begin
            if (go_o[k] && !never_fall) dly <= 1'b1;
            else if (dly) begin
                dly <= 1'b0;
                cnt <= low_cycles;
            end else if (cnt > 0) cnt <= cnt - 1;
        end
        assign done_i[k] = (cnt == 0) && (cyc >= hold_until);

        // Command monitor
        always @(negedge clk) begin
            if (go_o[k]) begin
                if (exp_q[k].size() == 0) begin
                    check_eq($sformatf("inst%0d_unexpected_go", k), 1, 0);
                end else begin
                    e = exp_q[k].pop_front();
                    check_eq($sformatf("inst%0d_x0", k), x0_o[k], e >> 8);
                    check_eq($sformatf("inst%0d_x1", k), x1_o[k], e >> 8);
                    check_eq($sformatf("inst%0d_y0", k), y0_o[k], 239);
                    check_eq($sformatf("inst%0d_y1", k), y1_o[k], e & 32'hFF);
                    check_eq($sformatf("inst%0d_thickness", k), th_o[k], exp_thick);
                    if (go_cnt[k] == 0) first_go_cyc[k] = cyc;
                    go_cnt[k]++;
                end
            end
            if (fd_o[k]) fd_cnt[k]++;
        end
    end

    // Expected bar list: bar i sits at X_ORIGIN + i*PITCH, exists while on
    // screen and within the bin count, and is drawn only if its clamped
    // height is nonzero.
    task automatic build_expect();
        int nb;
        int x;
        int h;
        for (int k = 0; k < 2; k++) begin
            nb = (k == 0) ? c_NB0 : c_NB1;
            exp_q[k].delete();
            for (int i = 0; i < nb; i++) begin
                x = 4 + 10 * i;
                if (x > 319) break;
                h = int'(ram[k][i]);
                if (h > 200) h = 200;
                if (h > 239) h = 239;
                if (h != 0) exp_q[k].push_back(int'(x * 256 + (239 - h)));
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s_go%0d", tag, k), go_o[k], 0);
            check_eq($sformatf("%s_busy%0d", tag, k), busy_o[k], 0);
            check_eq($sformatf("%s_fdone%0d", tag, k), fd_o[k], 0);
            check_eq($sformatf("%s_addr%0d", tag, k), addr_o[k], 0);
            check_eq($sformatf("%s_x0_%0d", tag, k), x0_o[k], 0);
            check_eq($sformatf("%s_x1_%0d", tag, k), x1_o[k], 0);
            check_eq($sformatf("%s_y0_%0d", tag, k), y0_o[k], 0);
            check_eq($sformatf("%s_y1_%0d", tag, k), y1_o[k], 0);
            check_eq($sformatf("%s_thick%0d", tag, k), th_o[k], 0);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++)
                ram[k][i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
    endtask

    // extra: 0 none, 1 Start pulse mid-frame, 2 Start on inst0 Frame_Done
    task automatic run_frame(input logic [8:0] t, input int hold_len,
                             input int extra, input bit chk_lat);
        int start_cyc;
        int waited;
        bit pulsed;
        build_expect();
        exp_thick = t;
        pulsed = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fd_cnt[k] = 0;
            go_cnt[k] = 0;
        end
        @(negedge clk);
        thick      = t;
        start      = 1'b1;
        start_cyc  = cyc;
        hold_until = cyc + hold_len;
        @(negedge clk);
        start = 1'b0;
        thick = 9'($urandom);
        check_eq("busy_after_start0", busy_o[0], 1);
        check_eq("busy_after_start1", busy_o[1], 1);
        waited = 0;
        while ((busy_o[0] || busy_o[1]) && waited < 5000) begin
            if (extra == 1 && waited == 10) begin
                start = 1'b1;
                @(negedge clk);
                waited++;
                start = 1'b0;
            end else if (extra == 2 && fd_o[0] && !pulsed) begin
                pulsed = 1'b1;
                start  = 1'b1;
                @(negedge clk);
                waited++;
                start = 1'b0;
                check_eq("start_on_frame_done_ignored", busy_o[0], 0);
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        check_eq("frame_completes_in_budget", waited < 5000, 1);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("inst%0d_missing_bars", k), exp_q[k].size(), 0);
            check_eq($sformatf("inst%0d_frame_done_count", k), fd_cnt[k], 1);
        end
        if (chk_lat) check_eq("start_to_first_go", first_go_cyc[0] - start_cyc, 3);
        if (hold_len > 3) check_eq("stall_release_cycle", first_go_cyc[0], hold_until);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int waited;
        for (int k = 0; k < 2; k++) begin
            fd_cnt[k] = 0;
            go_cnt[k] = 0;
            first_go_cyc[k] = 0;
            for (int i = 0; i < 256; i++) ram[k][i] = 8'd50;
        end
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // All bins 50: inst0 4 bars at 4..34, inst1 32 bars at 4..314
        low_cycles = 20;
        run_frame(9'd5, 0, 2, 1'b1);

        // Zero, over-clamp, zero, small
        fill_random();
        for (int k = 0; k < 2; k++) begin
            ram[k][0] = 8'd0;
            ram[k][1] = 8'd255;
            ram[k][2] = 8'd0;
            ram[k][3] = 8'd7;
        end
        low_cycles = 3;
        run_frame(9'd17, 0, 0, 1'b0);

        // Done held low at Start for 15 cycles
        fill_random();
        ram[0][0] = 8'd120;
        low_cycles = 5;
        run_frame(9'd300, 15, 0, 1'b0);

        // Drawer whose Done never falls
        never_fall = 1'b1;
        fill_random();
        run_frame(9'd1, 0, 0, 1'b0);
        never_fall = 1'b0;

        // Start pulsed while busy
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) ram[k][i] = 8'd90;
        low_cycles = 20;
        run_frame(9'd9, 0, 1, 1'b0);

        // Randomized frames
        for (int n = 0; n < 6; n++) begin
            fill_random();
            low_cycles = $urandom_range(0, 12);
            run_frame(9'($urandom), 0, 0, 1'b0);
        end

        // Reset in WAIT of the second bar
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) ram[k][i] = 8'd50;
            go_cnt[k] = 0;
            fd_cnt[k] = 0;
        end
        build_expect();
        low_cycles = 20;
        exp_thick  = 9'd33;
        @(negedge clk);
        thick = 9'd33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (go_cnt[0] < 2 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check_eq("second_go_seen", go_cnt[0], 2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("midreset");
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (80) @(negedge clk);
        check_eq("midreset_no_frame_done0", fd_cnt[0], 0);
        check_eq("midreset_no_frame_done1", fd_cnt[1], 0);
        check_eq("midreset_stays_idle", busy_o[0] | busy_o[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
